// File: rtl/exposure_readout_ctrl_if.sv
// Exposure/readout sequencer bus.
// Groups the camera-control request side (Init, Abort, ExpTime) with the
// pixel-array / ADC drive side (Erase, Expose, NRE, ADC, RowIdx, Busy, Done).
//   master : camera control logic (drives requests, observes sequencing)
//   slave  : exposure_readout_ctrl
interface exposure_readout_ctrl_if #(
    parameter int N_ROWS = 2,
    parameter int EXP_W  = 5,
    parameter int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
);
    logic              Init;
    logic              Abort;
    logic [EXP_W-1:0]  ExpTime;
    logic              Erase;
    logic              Expose;
    logic [N_ROWS-1:0] NRE;
    logic              ADC;
    logic [ROW_W-1:0]  RowIdx;
    logic              Busy;
    logic              Done;

    modport master (
        output Init, Abort, ExpTime,
        input  Erase, Expose, NRE, ADC, RowIdx, Busy, Done
    );

    modport slave (
        input  Init, Abort, ExpTime,
        output Erase, Expose, NRE, ADC, RowIdx, Busy, Done
    );
endinterface

// File: rtl/exposure_readout_ctrl.sv
// Exposure and readout sequencer for the pixel array.
// A rising edge on Init (in IDLE) releases erase, exposes for ExpTime cycles
// (0 treated as 1), then reads N_ROWS rows in ascending order: settle, ADC
// strobe, hold, gap. A one-cycle Done pulse ends the frame.
// Ports:
//   Clk   : clock, rising edge
//   Reset : asynchronous, active-high
//   bus   : exposure_readout_ctrl_if.slave (Init/Abort/ExpTime in;
//           Erase/Expose/NRE/ADC/RowIdx/Busy/Done out, all registered)
//
// state    | meaning
// ---------+---------------------------------------------
// IDLE     | array held in erase, waiting for Init edge
// EXPOSE   | exposure running, counts E cycles
// ROW_SEL  | NRE[r] high, settling SETTLE_CYC cycles
// ADC_HI   | NRE[r] and ADC strobe high, ADC_CYC cycles
// ROW_HOLD | NRE[r] high one cycle after the strobe
// ROW_GAP  | all NRE low one cycle between rows
// DONE     | one-cycle Done pulse, then IDLE
module exposure_readout_ctrl #(
    parameter int N_ROWS     = 2,
    parameter int EXP_W      = 5,
    parameter int SETTLE_CYC = 1,
    parameter int ADC_CYC    = 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    exposure_readout_ctrl_if.slave   bus
);
    localparam int ROW_W   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int SET_W   = $clog2(SETTLE_CYC + 1);
    localparam int ADCC_W  = $clog2(ADC_CYC + 1);
    localparam int CNT_W0  = (EXP_W > SET_W) ? EXP_W : SET_W;
    localparam int CNT_W   = (CNT_W0 > ADCC_W) ? CNT_W0 : ADCC_W;

    localparam logic [N_ROWS-1:0] NRE_ONE  = N_ROWS'(1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(N_ROWS - 1);
    localparam logic [CNT_W-1:0]  SET_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  ADC_LOAD = CNT_W'(ADC_CYC - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXPOSE   = 3'd1,
        ROW_SEL  = 3'd2,
        ADC_HI   = 3'd3,
        ROW_HOLD = 3'd4,
        ROW_GAP  = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               init_q;
    logic               start;
    logic [CNT_W-1:0]   e_len;
    logic               reading;

    logic               erase_q, erase_d;
    logic               expose_q, expose_d;
    logic [N_ROWS-1:0]  nre_q, nre_d;
    logic               adc_q, adc_d;
    logic [ROW_W-1:0]   row_idx_q, row_idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    assign start = (state_q == IDLE) && bus.Init && !init_q && !bus.Abort;
    assign e_len = (bus.ExpTime == '0) ? CNT_W'(1) : CNT_W'(bus.ExpTime);

    // Down-counters load "length - 1" so a phase ends when the count reads 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EXPOSE;
                    cnt_d   = e_len - CNT_W'(1);
                    row_d   = '0;
                end
            end
            EXPOSE: begin
                if (cnt_q == '0) begin
                    state_d = ROW_SEL;
                    cnt_d   = SET_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ROW_SEL: begin
                if (cnt_q == '0) begin
                    state_d = ADC_HI;
                    cnt_d   = ADC_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ADC_HI: begin
                if (cnt_q == '0) begin
                    state_d = ROW_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ROW_HOLD: state_d = ROW_GAP;
            ROW_GAP: begin
                if (row_q == ROW_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = ROW_SEL;
                    row_d   = row_q + ROW_W'(1);
                    cnt_d   = SET_LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
                row_d   = '0;
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
                cnt_d   = '0;
            end
        endcase

        if (bus.Abort && (state_q != IDLE)) begin
            state_d = IDLE;
            row_d   = '0;
            cnt_d   = '0;
        end

        // Outputs are decoded from the next state so they register in step
        // with the state itself.
        reading   = (state_d == ROW_SEL) || (state_d == ADC_HI) || (state_d == ROW_HOLD);
        erase_d   = (state_d == IDLE);
        expose_d  = (state_d == EXPOSE);
        nre_d     = reading ? (NRE_ONE << row_d) : '0;
        adc_d     = (state_d == ADC_HI);
        row_idx_d = reading ? row_d : '0;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            init_q    <= 1'b1;
            erase_q   <= 1'b1;
            expose_q  <= 1'b0;
            nre_q     <= '0;
            adc_q     <= 1'b0;
            row_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            init_q    <= bus.Init;
            erase_q   <= erase_d;
            expose_q  <= expose_d;
            nre_q     <= nre_d;
            adc_q     <= adc_d;
            row_idx_q <= row_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.Erase  = erase_q;
    assign bus.Expose = expose_q;
    assign bus.NRE    = nre_q;
    assign bus.ADC    = adc_q;
    assign bus.RowIdx = row_idx_q;
    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
endmodule

// File: tb/tb_exposure_readout_ctrl.sv
// Testbench for exposure_readout_ctrl. Two instances: defaults (A) and
// N_ROWS=4, SETTLE_CYC=2, ADC_CYC=3 (B). Expected per-cycle outputs of each
// frame are queued when Init is driven; a monitor pops and compares them.
module tb_exposure_readout_ctrl;
    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    exposure_readout_ctrl_if #(.N_ROWS(2), .EXP_W(5)) bus_a ();
    exposure_readout_ctrl_if #(.N_ROWS(4), .EXP_W(5)) bus_b ();

    exposure_readout_ctrl #(.N_ROWS(2), .EXP_W(5), .SETTLE_CYC(1), .ADC_CYC(1)) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(bus_a.slave));
    exposure_readout_ctrl #(.N_ROWS(4), .EXP_W(5), .SETTLE_CYC(2), .ADC_CYC(3)) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(bus_b.slave));

    typedef struct packed {
        logic       erase;
        logic       expose;
        logic       adc;
        logic       busy;
        logic       done;
        logic [3:0] nre;
        logic [1:0] row_idx;
    } vec_t;

    vec_t q_a[$];
    vec_t q_b[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   mon_en      = 1'b0;
    int   cyc         = 0;
    vec_t ea, eb, oa, ob;

    function automatic vec_t idle_vec();
        vec_t v = '0;
        v.erase = 1'b1;
        return v;
    endfunction

    function automatic vec_t obs_a();
        vec_t v;
        v.erase = bus_a.Erase; v.expose = bus_a.Expose; v.adc = bus_a.ADC;
        v.busy = bus_a.Busy; v.done = bus_a.Done;
        v.nre = {2'b00, bus_a.NRE}; v.row_idx = {1'b0, bus_a.RowIdx};
        return v;
    endfunction

    function automatic vec_t obs_b();
        vec_t v;
        v.erase = bus_b.Erase; v.expose = bus_b.Expose; v.adc = bus_b.ADC;
        v.busy = bus_b.Busy; v.done = bus_b.Done;
        v.nre = bus_b.NRE; v.row_idx = bus_b.RowIdx;
        return v;
    endfunction

    // Frame reference: E expose cycles, then per row settle/strobe/hold/gap,
    // then one Done cycle.
    function automatic void push_frame(int which, int e, int n, int s, int a);
        vec_t v;
        vec_t fr[$];
        for (int i = 0; i < e; i++) begin
            v = '0; v.expose = 1'b1; v.busy = 1'b1; fr.push_back(v);
        end
        for (int r = 0; r < n; r++) begin
            v = '0; v.busy = 1'b1; v.nre = 4'(1 << r); v.row_idx = 2'(r);
            for (int i = 0; i < s; i++) fr.push_back(v);
            v.adc = 1'b1;
            for (int i = 0; i < a; i++) fr.push_back(v);
            v.adc = 1'b0;
            fr.push_back(v);
            v = '0; v.busy = 1'b1; fr.push_back(v);
        end
        v = '0; v.busy = 1'b1; v.done = 1'b1; fr.push_back(v);
        foreach (fr[i]) begin
            if (which == 0) q_a.push_back(fr[i]);
            else            q_b.push_back(fr[i]);
        end
    endfunction

    always @(posedge Clk) begin
        cyc++;
        #1;
        if (mon_en && !Reset) begin
            ea = (q_a.size() > 0) ? q_a.pop_front() : idle_vec();
            eb = (q_b.size() > 0) ? q_b.pop_front() : idle_vec();
            oa = obs_a();
            ob = obs_b();
            vectors++;
            if (oa !== ea) begin
                miscompares++;
                $display("FAIL trace_a cycle %0d: got %b required %b", cyc, oa, ea);
            end
            vectors++;
            if (ob !== eb) begin
                miscompares++;
                $display("FAIL trace_b cycle %0d: got %b required %b", cyc, ob, eb);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic test_reset();
        bus_a.Init = 0; bus_a.Abort = 0; bus_a.ExpTime = 0;
        bus_b.Init = 0; bus_b.Abort = 0; bus_b.ExpTime = 0;
        #1 Reset = 1'b1;
        #1;
        vectors++;
        if (obs_a() !== idle_vec()) begin
            miscompares++;
            $display("FAIL reset_a: got %b required %b", obs_a(), idle_vec());
        end
        vectors++;
        if (obs_b() !== idle_vec()) begin
            miscompares++;
            $display("FAIL reset_b: got %b required %b", obs_b(), idle_vec());
        end
        tick(2);
        Reset  = 1'b0;
        mon_en = 1'b1;
        tick(2);
    endtask

    task automatic test_default_frame();
        int busy_cnt = 0, done_cnt = 0;
        bus_a.ExpTime = 5; bus_a.Init = 1; push_frame(0, 5, 2, 1, 1);
        tick(1);
        bus_a.Init = 0;
        busy_cnt += int'(bus_a.Busy);
        for (int i = 0; i < 19; i++) begin
            tick(1);
            busy_cnt += int'(bus_a.Busy);
            done_cnt += int'(bus_a.Done);
        end
        vectors++;
        if (busy_cnt != 14) begin
            miscompares++;
            $display("FAIL default_busy_len: got %0d required 14", busy_cnt);
        end
        vectors++;
        if (done_cnt != 1) begin
            miscompares++;
            $display("FAIL default_done_count: got %0d required 1", done_cnt);
        end
    endtask

    task automatic test_exptime();
        int exp_cnt = 0;
        bus_a.ExpTime = 0; bus_a.Init = 1; push_frame(0, 1, 2, 1, 1);
        tick(1);
        bus_a.Init = 0;
        exp_cnt += int'(bus_a.Expose);
        for (int i = 0; i < 15; i++) begin
            tick(1);
            exp_cnt += int'(bus_a.Expose);
        end
        vectors++;
        if (exp_cnt != 1) begin
            miscompares++;
            $display("FAIL exptime_zero_len: got %0d required 1", exp_cnt);
        end
        exp_cnt = 0;
        bus_a.ExpTime = 6; bus_a.Init = 1; push_frame(0, 6, 2, 1, 1);
        tick(1);
        bus_a.Init = 0; bus_a.ExpTime = 2;
        exp_cnt += int'(bus_a.Expose);
        tick(1);
        bus_a.ExpTime = 31;
        exp_cnt += int'(bus_a.Expose);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            exp_cnt += int'(bus_a.Expose);
        end
        vectors++;
        if (exp_cnt != 6) begin
            miscompares++;
            $display("FAIL exptime_change_len: got %0d required 6", exp_cnt);
        end
    endtask

    task automatic test_wide();
        int busy_cnt = 0, adc_cnt = 0;
        int nre_cnt[4] = '{0, 0, 0, 0};
        bus_b.ExpTime = 7; bus_b.Init = 1; push_frame(1, 7, 4, 2, 3);
        tick(1);
        bus_b.Init = 0;
        for (int i = 0; i < 45; i++) begin
            busy_cnt += int'(bus_b.Busy);
            adc_cnt  += int'(bus_b.ADC);
            for (int b = 0; b < 4; b++) nre_cnt[b] += int'(bus_b.NRE[b]);
            tick(1);
        end
        vectors++;
        if (busy_cnt != 36) begin
            miscompares++;
            $display("FAIL wide_busy_len: got %0d required 36", busy_cnt);
        end
        vectors++;
        if (adc_cnt != 12) begin
            miscompares++;
            $display("FAIL wide_adc_cycles: got %0d required 12", adc_cnt);
        end
        vectors++;
        if (nre_cnt[3] != 6) begin
            miscompares++;
            $display("FAIL wide_nre3_cycles: got %0d required 6", nre_cnt[3]);
        end
    endtask

    task automatic test_init_held();
        int done_cnt = 0;
        bus_a.ExpTime = 5; bus_a.Init = 1; push_frame(0, 5, 2, 1, 1);
        for (int i = 0; i < 40; i++) begin
            tick(1);
            done_cnt += int'(bus_a.Done);
        end
        bus_a.Init = 0;
        tick(2);
        bus_a.Init = 1; push_frame(0, 5, 2, 1, 1);
        tick(1);
        bus_a.Init = 0;
        tick(8);
        bus_a.Init = 1;
        tick(1);
        bus_a.Init = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            done_cnt += int'(bus_a.Done);
        end
        vectors++;
        if (done_cnt != 2) begin
            miscompares++;
            $display("FAIL init_held_done_count: got %0d required 2", done_cnt);
        end
    endtask

    task automatic test_abort();
        int done_cnt = 0;
        bus_a.ExpTime = 5; bus_a.Init = 1; push_frame(0, 5, 2, 1, 1);
        tick(1);
        bus_a.Init = 0;
        tick(10);
        vectors++;
        if ({bus_a.ADC, bus_a.NRE} !== 3'b110) begin
            miscompares++;
            $display("FAIL abort_pre_state: got adc/nre %b required 110", {bus_a.ADC, bus_a.NRE});
        end
        bus_a.Abort = 1;
        q_a.delete();
        tick(1);
        bus_a.Abort = 0;
        vectors++;
        if ({bus_a.Erase, bus_a.Busy, bus_a.ADC, bus_a.NRE, bus_a.Done} !== 6'b100000) begin
            miscompares++;
            $display("FAIL abort_outputs: got %b required 100000",
                     {bus_a.Erase, bus_a.Busy, bus_a.ADC, bus_a.NRE, bus_a.Done});
        end
        for (int i = 0; i < 5; i++) begin
            tick(1);
            done_cnt += int'(bus_a.Done);
        end
        vectors++;
        if (done_cnt != 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d required 0", done_cnt);
        end
        bus_a.Init = 1; push_frame(0, 5, 2, 1, 1);
        tick(1);
        bus_a.Init = 0;
        tick(16);
        // Abort in IDLE blocks a coincident start; the edge is then gone.
        bus_a.Init = 1; bus_a.Abort = 1;
        tick(1);
        bus_a.Abort = 0;
        tick(3);
        vectors++;
        if (bus_a.Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle_blocks: got busy %b required 0", bus_a.Busy);
        end
        bus_a.Init = 0;
        tick(1);
    endtask

    task automatic test_back_to_back();
        bus_a.ExpTime = 5; bus_a.Init = 1; push_frame(0, 5, 2, 1, 1);
        tick(1);
        bus_a.Init = 0;
        tick(14);
        bus_a.Init = 1; push_frame(0, 5, 2, 1, 1);
        tick(1);
        bus_a.Init = 0;
        vectors++;
        if ({bus_a.Busy, bus_a.Expose} !== 2'b11) begin
            miscompares++;
            $display("FAIL back_to_back_start: got busy/expose %b required 11", {bus_a.Busy, bus_a.Expose});
        end
        tick(16);
    endtask

    task automatic test_reset_mid();
        bus_a.ExpTime = 5; bus_a.Init = 1; push_frame(0, 5, 2, 1, 1);
        tick(3);
        Reset = 1'b1;
        q_a.delete();
        #1;
        vectors++;
        if (obs_a() !== idle_vec()) begin
            miscompares++;
            $display("FAIL reset_mid_async: got %b required %b", obs_a(), idle_vec());
        end
        tick(2);
        Reset = 1'b0;
        tick(5);
        vectors++;
        if (bus_a.Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_init_held: got busy %b required 0", bus_a.Busy);
        end
        bus_a.Init = 0;
        tick(1);
        bus_a.Init = 1; push_frame(0, 5, 2, 1, 1);
        tick(1);
        bus_a.Init = 0;
        vectors++;
        if (bus_a.Expose !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_fresh_start: got expose %b required 1", bus_a.Expose);
        end
        tick(16);
    endtask

    initial begin
        test_reset();
        test_default_frame();
        test_exptime();
        test_wide();
        test_init_held();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
